// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between I-cache and D-cache
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;

    logic i_req, d_req;
    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
        end
    end

    // Ties go to whichever side was not granted last; hold registers load only on a grant.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = d_address;
                    wdata_d  = d_wdata;
                    write_d  = d_write;
                end else if (i_req) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = i_address;
                    wdata_d  = '0;
                    write_d  = 1'b0;
                end
            end
            SERVE_I: if (pmem_resp) state_d = IDLE;
            SERVE_D: if (pmem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commands decode registered state only; resp and rdata pass straight through from memory.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        case (state_q)
            SERVE_I: begin
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = !write_q;
                pmem_write = write_q;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [LINE_W-1:0] a5, x5a, x11;
        logic              exp_d;
        a5  = {32{8'hA5}};
        x5a = {32{8'h5A}};
        x11 = {32{8'h11}};

        // Reset held with an I request pending
        rst = 1'b0; i_read = 1'b1; i_address = 32'h40;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        step(); step();
        #1;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        rst = 1'b1;
        step(); #1;
        chk("post_rst_pmem_read", pmem_read, 1);
        chk("post_rst_addr", pmem_address, 32'h40);
        pmem_resp = 1'b1; pmem_rdata = x11; #1;
        chk("post_rst_i_resp", i_resp, 1);
        step(); pmem_resp = 1'b0; i_read = 1'b0; #1;
        chk("post_rst_idle", pmem_read, 0);

        // Single I read with 4-cycle memory latency
        i_read = 1'b1; i_address = 32'h60;
        step(); #1;
        chk("iread_cmd", pmem_read, 1);
        chk("iread_addr", pmem_address, 32'h60);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("iread_wait_no_resp", i_resp, 0);
        end
        step(); pmem_resp = 1'b1; pmem_rdata = a5; #1;
        chk("iread_resp", i_resp, 1);
        chk("iread_rdata", i_rdata, a5);
        chk("iread_no_dresp", d_resp, 0);
        step(); pmem_resp = 1'b0; i_read = 1'b0; #1;
        chk("iread_idle_resp", i_resp, 0);

        // Fresh reset so the first tie goes to D
        rst = 1'b0; step(); rst = 1'b1;
        i_read = 1'b1; i_address = 32'h80;
        d_write = 1'b1; d_address = 32'h100; d_wdata = x5a;
        step(); #1;
        chk("tie_d_write", pmem_write, 1);
        chk("tie_d_noread", pmem_read, 0);
        chk("tie_d_addr", pmem_address, 32'h100);
        chk("tie_d_wdata", pmem_wdata, x5a);
        pmem_resp = 1'b1; #1;
        chk("tie_d_resp", d_resp, 1);
        chk("tie_no_iresp", i_resp, 0);
        step(); pmem_resp = 1'b0; d_write = 1'b0; #1;
        chk("tie_dead_write", pmem_write, 0);
        chk("tie_dead_read", pmem_read, 0);
        step(); #1;
        chk("tie_i_read", pmem_read, 1);
        chk("tie_i_addr", pmem_address, 32'h80);
        pmem_resp = 1'b1; #1;
        chk("tie_i_resp", i_resp, 1);
        step(); pmem_resp = 1'b0; i_read = 1'b0;

        // Round robin with both requests held: D, I, D, I
        i_read = 1'b1; i_address = 32'h1C0;
        d_read = 1'b1; d_address = 32'h240;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            step(); #1;
            chk("rr_cmd", pmem_read, 1);
            chk("rr_addr", pmem_address, exp_d ? 32'h240 : 32'h1C0);
            pmem_resp = 1'b1; #1;
            chk("rr_dresp", d_resp, exp_d);
            chk("rr_iresp", i_resp, !exp_d);
            step(); pmem_resp = 1'b0; #1;
            chk("rr_dead", pmem_read, 0);
        end
        i_read = 1'b0; d_read = 1'b0;

        // Hold registers ignore address changes mid-transaction
        d_read = 1'b1; d_address = 32'h200;
        step(); d_address = 32'h300; #1;
        chk("hold_addr0", pmem_address, 32'h200);
        step(); #1;
        chk("hold_addr1", pmem_address, 32'h200);
        pmem_resp = 1'b1; #1;
        chk("hold_resp", d_resp, 1);
        chk("hold_addr_resp", pmem_address, 32'h200);
        step(); pmem_resp = 1'b0; d_read = 1'b0;

        // Read and write together means write
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h400;
        step(); #1;
        chk("rw_write", pmem_write, 1);
        chk("rw_noread", pmem_read, 0);
        pmem_resp = 1'b1; #1;
        step(); pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;

        // Reset during SERVE_D, late pmem_resp ignored
        d_write = 1'b1; d_address = 32'h500;
        step(); #1;
        chk("midrst_cmd", pmem_write, 1);
        rst = 1'b0;
        step(); #1;
        chk("midrst_write_drop", pmem_write, 0);
        rst = 1'b1; d_write = 1'b0; pmem_resp = 1'b1; #1;
        chk("midrst_no_dresp", d_resp, 0);
        step(); #1;
        chk("midrst_idle_write", pmem_write, 0);
        chk("midrst_idle_read", pmem_read, 0);
        chk("midrst_idle_dresp", d_resp, 0);
        pmem_resp = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
